mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the CPU's single-port memory between the instruction-fetch requester (IF) and the data-memory requester (DM/MEM stage).
- Uses round-robin arbitration on conflicts, with a registered request/response handshake on each side and a watchdog timeout on the memory side.
- Sits between the CPU core and the unified memory model; the core stalls on each port until the matching ready pulse.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- TIMEOUT_CYC, 16, maximum cycles in ISSUE before abort; 0 disables the watchdog.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held until if_ready.
- if_addr  in  ADDR_W  fetch address (PC).
- if_rdata  out  DATA_W  fetched instruction, valid while if_ready=1.
- if_ready  out  1  one-cycle completion pulse for IF.
- dm_req  in  1  data request; held until dm_ready.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  write data.
- dm_be  in  DATA_W/8  byte enables.
- dm_rdata  out  DATA_W  read data, valid while dm_ready=1.
- dm_ready  out  1  one-cycle completion pulse for DM.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_be  out  DATA_W/8  memory byte enables.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion from memory; may arrive in the first mem_req cycle.
- bus_err  out  1  pulses together with if_ready/dm_ready when the access timed out.

Behaviour:
- Reset (async, any state):
  - state=IDLE, last_grant=IF, timeout counter=0.
  - All outputs 0, including if_rdata and dm_rdata.
- States: IDLE, ISSUE, RESP.
- IDLE:
  - No req: stay in IDLE.
  - Only one req high: grant it.
  - Both high: grant the port opposite last_grant, so the first conflict after reset goes to DM.
  - On grant: latch the payload into the mem_* registers, update last_grant, go to ISSUE.
  - mem_req=1 from the cycle after req is sampled.
- IF grant payload: mem_we=0, mem_be=all ones, mem_addr=if_addr, mem_wdata=0.
- DM grant payload: dm_we/dm_addr/dm_wdata/dm_be passed through unchanged.
- ISSUE:
  - mem_req and payload held stable. Counter increments each cycle without ack.
  - mem_ack=1 sampled: go to RESP; mem_req/mem_we cleared at that edge.
  - Granted read: latch mem_rdata into if_rdata or dm_rdata. Granted write: dm_rdata loaded with 0.
  - Timeout: counter reaches TIMEOUT_CYC-1 with no ack (TIMEOUT_CYC≠0) → go to RESP with bus_err=1, rdata=0, mem_req cleared.
- RESP:
  - Exactly one cycle. Granted port's ready=1; bus_err per the above.
  - Counter cleared; next state IDLE.
- Requester rules:
  - A requester deasserts req at the edge where it samples ready=1.
  - req high in IDLE is always a new request, so back-to-back requests are legal.
  - The non-granted requester keeps req held and is served next; no request is ever dropped.
- Timing:
  - Minimum latency from req sampled to ready is 2 cycles (ack in first ISSUE cycle).
  - Maximum throughput is one access per 3 cycles.
- Spurious mem_ack in IDLE or RESP is ignored and has no effect on state or outputs.
- if_ready and dm_ready are never high in the same cycle. Ready for an idle port stays 0.
- rdata registers hold their value until the next completion on that port.
- Reset asserted mid-ISSUE: mem_req drops immediately (async). The requester must re-issue after reset.

Test Plan:
1. After reset, IF-only read of 0x0000_0004, memory acks in the first cycle with 0x2008_0005 → mem_req high for 1 cycle, if_ready pulses 2 cycles after req with if_rdata=0x2008_0005, bus_err=0.
2. IF and DM requesting in the same cycle just after reset:
   - Stimulus: DM write addr 0x10, wdata 0xDEAD_BEEF, be 4'b0011; both ack after 1 cycle.
   - Response: DM served first (mem_we=1, mem_be=4'b0011), then IF.
   - On the next conflict IF wins (round-robin).
3. DM read with ack delayed 5 cycles, mem_rdata=0x1234_5678 → mem_req held 6 cycles with a stable payload, dm_ready one cycle with dm_rdata=0x1234_5678, and if_ready stays 0 throughout.
4. TIMEOUT_CYC=4, no ack → mem_req high for exactly 4 cycles, then dm_ready=1 and bus_err=1 together with dm_rdata=0, then IDLE.
5. Reset asserted during ISSUE (before ack) → mem_req and all outputs go to 0 without waiting for a clock edge. After release, a new IF request is granted normally. A late mem_ack arriving in IDLE produces no ready pulse.
6. IF holds req high continuously for 3 fetches (addresses 0x0, 0x4, 0x8), ack in the first cycle each time → three if_ready pulses spaced 3 cycles apart, with matching rdata.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one single-port memory between instruction fetch (IF) and data (DM).
// Latency: two cycles minimum from req sampled to ready (IDLE grant, ISSUE with ack, RESP pulse); at most one access per three cycles.
// Backpressure: requesters hold req until their ready pulse; memory stalls via mem_ack, bounded by a TIMEOUT_CYC watchdog.
// Ports: clk/rst (async, active high);
//        IF  : if_req, if_addr -> if_rdata, if_ready
//        DM  : dm_req, dm_we, dm_addr, dm_wdata, dm_be -> dm_rdata, dm_ready
//        MEM : mem_req, mem_we, mem_addr, mem_wdata, mem_be <- mem_rdata, mem_ack
//        bus_err pulses with the ready of an access that was aborted by the watchdog.
module mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ready,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_be,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic                bus_err
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } mem_cmd_t;

    state_t            state_q, state_d;
    logic              gnt_dm_q, gnt_dm_d;     // owner of the current (or last) grant: 1 = DM, 0 = IF
    logic [CNT_W-1:0]  cnt_q, cnt_d;           // ISSUE cycles spent without ack
    logic              mem_req_q, mem_req_d;
    mem_cmd_t          cmd_q, cmd_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              err_q, err_d;           // current access was aborted by the watchdog
    logic              timeout;

    // Ack wins over the watchdog when both land in the same cycle.
    assign timeout = (TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            gnt_dm_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_dm_q <= gnt_dm_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        gnt_dm_d = gnt_dm_q;
        unique case (state_q)
            S_IDLE: begin
                if (if_req || dm_req) begin
                    state_d = S_ISSUE;
                    // On a conflict the port that did not win last time goes first.
                    gnt_dm_d = dm_req && (!if_req || !gnt_dm_q);
                end
            end
            S_ISSUE: begin
                if (mem_ack || timeout) begin
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        if_ready = (state_q == S_RESP) && !gnt_dm_q;
        dm_ready = (state_q == S_RESP) && gnt_dm_q;
        bus_err  = (state_q == S_RESP) && err_q;
    end

    // Datapath next-state: command latch, watchdog count, response capture
    always_comb begin
        cnt_d      = '0;
        mem_req_d  = mem_req_q;
        cmd_d      = cmd_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        err_d      = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (if_req || dm_req) begin
                    mem_req_d = 1'b1;
                    err_d     = 1'b0;
                    if (gnt_dm_d) begin
                        cmd_d.we    = dm_we;
                        cmd_d.addr  = dm_addr;
                        cmd_d.wdata = dm_wdata;
                        cmd_d.be    = dm_be;
                    end else begin
                        cmd_d.we    = 1'b0;
                        cmd_d.addr  = if_addr;
                        cmd_d.wdata = '0;
                        cmd_d.be    = '1;
                    end
                end
            end
            S_ISSUE: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    cmd_d.we  = 1'b0;
                    if (gnt_dm_q) begin
                        dm_rdata_d = cmd_q.we ? '0 : mem_rdata;
                    end else begin
                        if_rdata_d = mem_rdata;
                    end
                end else if (timeout) begin
                    mem_req_d = 1'b0;
                    cmd_d.we  = 1'b0;
                    err_d     = 1'b1;
                    if (gnt_dm_q) begin
                        dm_rdata_d = '0;
                    end else begin
                        if_rdata_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            mem_req_q  <= 1'b0;
            cmd_q      <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            err_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            mem_req_q  <= mem_req_d;
            cmd_q      <= cmd_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            err_q      <= err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = cmd_q.we;
    assign mem_addr  = cmd_q.addr;
    assign mem_wdata = cmd_q.wdata;
    assign mem_be    = cmd_q.be;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;

endmodule
